// File: rtl/array_arbiter_pkg.sv
// Shared types and width constants for the array port arbiter and its picker.
package array_arbiter_pkg;

  localparam int INT_W  = 8;
  localparam int ADDR_W = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single-entry pool.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/array_arbiter_if.sv
// Requester-side and memory-side signals of the shared array port, flattened per requester.
interface array_arbiter_if
  import array_arbiter_pkg::*;
#(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*INT_W-1:0]  req_di;
  logic [NREQ-1:0]        req_ready;
  logic [INT_W-1:0]       req_do;

  logic                   mem_valid;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [INT_W-1:0]       mem_di;
  logic [INT_W-1:0]       mem_do;
  logic                   mem_ready;

  // Arbiter view: serves the requesters, drives the array.
  modport slave (
    input  req_valid, req_lock, req_we, req_addr, req_di,
    output req_ready, req_do,
    output mem_valid, mem_we, mem_addr, mem_di,
    input  mem_do, mem_ready
  );

  // Environment view: requesters plus the array instance.
  modport master (
    output req_valid, req_lock, req_we, req_addr, req_di,
    input  req_ready, req_do,
    input  mem_valid, mem_we, mem_addr, mem_di,
    output mem_do, mem_ready
  );

endinterface

// File: rtl/array_arbiter_rr_pick.sv
// Combinational round-robin picker: first set valid bit at or after ptr, modulo N.
// Zero latency; no state, so no backpressure of its own.
module array_arbiter_rr_pick
  import array_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  function automatic logic [IW-1:0] offset(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest valid candidate is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (valid[offset(ptr, k)]) begin
        any = 1'b1;
        idx = offset(ptr, k);
      end
    end
  end

endmodule

// File: rtl/array_arbiter.sv
// Round-robin arbiter sharing one array port among NREQ requesters, with optional bounded lock.
// One idle cycle of arbitration per grant; requesters wait with req_ready=0 until mem_ready completes theirs.
module array_arbiter
  import array_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int LOCK_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  array_arbiter_if.slave bus
);

  localparam int GW  = idx_w(NREQ);
  localparam int LCW = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'((LOCK_MAX > 0) ? LOCK_MAX - 1 : 0);

  arb_state_e     state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

  logic           pick_any;
  logic [GW-1:0]  pick_idx;
  logic [GW-1:0]  grant_inc;
  logic           busy;
  logic           gnt_vld;
  logic           keep;
  logic           done;

  array_arbiter_rr_pick #(
    .N (NREQ)
  ) u_pick (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_comb begin
    grant_inc = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + GW'(1);
    busy      = (state_q == ARB_BUSY);
    gnt_vld   = bus.req_valid[grant_q];
    keep      = bus.req_lock[grant_q] && ((LOCK_MAX == 0) || (lock_cnt_q < LOCK_LAST));
    done      = busy && gnt_vld && bus.mem_ready && !rst;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!gnt_vld) begin
          // Requester withdrew before completion: release without a ready pulse.
          state_d    = ARB_IDLE;
          ptr_d      = grant_inc;
          lock_cnt_d = '0;
        end else if (bus.mem_ready) begin
          if (keep) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end else begin
            state_d    = ARB_IDLE;
            ptr_d      = grant_inc;
            lock_cnt_d = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Reset masks the port so an in-flight transaction can neither complete nor write.
  always_comb begin
    bus.mem_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_di    = '0;
    bus.req_ready = '0;
    bus.req_do    = '0;
    if (busy && !rst) begin
      bus.mem_valid = gnt_vld;
      bus.mem_we    = bus.req_we[grant_q];
      bus.mem_addr  = bus.req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
      bus.mem_di    = bus.req_di[int'(grant_q)*INT_W +: INT_W];
    end
    if (done) begin
      bus.req_ready[grant_q] = 1'b1;
      bus.req_do             = bus.mem_do;
    end
  end

  a_ready_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready));
  a_ready_granted: assert property (@(posedge clk)
    (bus.req_ready == '0) || (busy && bus.req_ready[grant_q]));
  a_idle_quiet: assert property (@(posedge clk) busy || !bus.mem_valid);

endmodule

// File: tb/tb_array_arbiter.sv
// Bench for array_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_array_arbiter;
  import array_arbiter_pkg::*;

  localparam int NREQ     = 2;
  localparam int LOCK_MAX = 4;
  localparam int DEPTH    = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  array_arbiter_if #(.NREQ(NREQ)) bus ();

  array_arbiter #(
    .NREQ     (NREQ),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       we;
    logic       lock;
    logic [7:0] addr;
    logic [7:0] di;
  } txn_t;

  txn_t       tq [NREQ][DEPTH];
  int         q_head [NREQ];
  int         q_tail [NREQ];
  logic [7:0] arr [256];
  int         log_id[$];
  int         log_data[$];
  int         dut_rdy_cnt [NREQ];

  int n_vec = 0;
  int n_err = 0;

  // Model state: current owner of the port (-1 = none), search start, completions this tenure.
  int m_owner, m_ptr, m_streak;

  int   ready_pct, abort_pct;
  logic mem_hold, rst_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push(input int i, input logic we, input logic lock,
                      input logic [7:0] addr, input logic [7:0] di);
    tq[i][q_tail[i] % DEPTH] = '{we: we, lock: lock, addr: addr, di: di};
    q_tail[i]++;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += q_tail[i] - q_head[i];
    return s;
  endfunction

  task automatic release_owner();
    m_ptr    = (m_owner + 1) % NREQ;
    m_owner  = -1;
    m_streak = 0;
  endtask

  task automatic check_and_step();
    logic             e_mv, e_we, done;
    logic [7:0]       e_addr, e_di, e_do;
    logic [NREQ-1:0]  e_rdy;
    e_mv = 0; e_we = 0; e_addr = 0; e_di = 0; e_do = 0; e_rdy = '0; done = 0;
    if (!rst && m_owner >= 0) begin
      e_mv   = bus.req_valid[m_owner];
      e_we   = bus.req_we[m_owner];
      e_addr = bus.req_addr[m_owner*8 +: 8];
      e_di   = bus.req_di[m_owner*8 +: 8];
      done   = e_mv && bus.mem_ready;
      if (done) begin
        e_rdy[m_owner] = 1'b1;
        e_do           = bus.mem_do;
      end
    end
    chk("mem_valid", 32'(bus.mem_valid), 32'(e_mv));
    chk("mem_we",    32'(bus.mem_we),    32'(e_we));
    chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
    chk("mem_di",    32'(bus.mem_di),    32'(e_di));
    chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
    chk("req_do",    32'(bus.req_do),    32'(e_do));

    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) dut_rdy_cnt[i]++;
    if (bus.mem_valid && bus.mem_ready && bus.mem_we) arr[bus.mem_addr] = bus.mem_di;

    if (done) begin
      log_id.push_back(m_owner);
      log_data.push_back(int'(bus.req_do));
      q_head[m_owner]++;
    end

    if (rst) begin
      m_owner = -1; m_ptr = 0; m_streak = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_valid[(m_ptr + k) % NREQ]) begin
          m_owner = (m_ptr + k) % NREQ;
          break;
        end
      end
    end else if (!e_mv) begin
      release_owner();
    end else if (done) begin
      if (bus.req_lock[m_owner] && (LOCK_MAX == 0 || m_streak + 1 < LOCK_MAX)) m_streak++;
      else release_owner();
    end
  endtask

  task automatic cycle();
    txn_t t;
    @(posedge clk);
    #1;
    rst = rst_next;
    for (int i = 0; i < NREQ; i++) begin
      if (q_tail[i] != q_head[i] && $urandom_range(0, 99) >= abort_pct) begin
        t = tq[i][q_head[i] % DEPTH];
        bus.req_valid[i]        = 1'b1;
        bus.req_lock[i]         = t.lock;
        bus.req_we[i]           = t.we;
        bus.req_addr[i*8 +: 8]  = t.addr;
        bus.req_di[i*8 +: 8]    = t.di;
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_lock[i]         = 1'b0;
        bus.req_we[i]           = 1'b0;
        bus.req_addr[i*8 +: 8]  = 8'($urandom);
        bus.req_di[i*8 +: 8]    = 8'($urandom);
      end
    end
    #1;
    bus.mem_ready = bus.mem_valid && !mem_hold && ($urandom_range(0, 99) < ready_pct);
    bus.mem_do    = bus.mem_valid ? arr[bus.mem_addr] : 8'($urandom);
    @(negedge clk);
    check_and_step();
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    while (pending() != 0 && n < max_cycles) begin
      cycle();
      n++;
    end
    chk({tag, "_drain_timeout"}, 32'(pending()), 32'd0);
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    rst_next = 1'b1;
    cycle();
    rst_next = 1'b0;
  endtask

  task automatic clear_logs();
    log_id.delete();
    log_data.delete();
    for (int i = 0; i < NREQ; i++) dut_rdy_cnt[i] = 0;
  endtask

  int first1;

  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.req_lock = '0; bus.req_we = '0;
    bus.req_addr = '0; bus.req_di = '0; bus.mem_do = '0; bus.mem_ready = 1'b0;
    for (int a = 0; a < 256; a++) arr[a] = 8'h00;
    for (int i = 0; i < NREQ; i++) begin q_head[i] = 0; q_tail[i] = 0; end
    m_owner = -1; m_ptr = 0; m_streak = 0;
    ready_pct = 50; abort_pct = 0; mem_hold = 1'b0; rst_next = 1'b0;

    do_reset();
    do_reset();
    cycle();
    chk("reset_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);

    // Single read.
    arr[3] = 8'd42;
    clear_logs();
    push(0, 1'b0, 1'b0, 8'd3, 8'd0);
    drain("t1", 200);
    chk("t1_count",  32'(log_id.size()), 32'd1);
    chk("t1_id",     32'(log_id[0]), 32'd0);
    chk("t1_data",   32'(log_data[0]), 32'd42);
    chk("t1_rdy0",   32'(dut_rdy_cnt[0]), 32'd1);
    chk("t1_rdy1",   32'(dut_rdy_cnt[1]), 32'd0);

    // Simultaneous writes after reset.
    do_reset();
    clear_logs();
    push(0, 1'b1, 1'b0, 8'd1, 8'd5);
    push(1, 1'b1, 1'b0, 8'd1, 8'd9);
    drain("t2", 200);
    chk("t2_first",  32'(log_id[0]), 32'd0);
    chk("t2_second", 32'(log_id[1]), 32'd1);
    chk("t2_arr1",   32'(arr[1]), 32'd9);

    // Fairness with both requesters saturated.
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      push(0, 1'b1, 1'b0, 8'(20 + k), 8'(k));
      push(1, 1'b1, 1'b0, 8'(30 + k), 8'(k));
    end
    drain("t3", 400);
    chk("t3_count", 32'(log_id.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk($sformatf("t3_order%0d", k), 32'(log_id[k]), 32'(k % 2));

    // Atomic read-modify-write under lock.
    arr[3] = 8'd42;
    clear_logs();
    push(0, 1'b0, 1'b1, 8'd3, 8'd0);
    push(0, 1'b1, 1'b0, 8'd3, 8'd43);
    push(1, 1'b1, 1'b0, 8'd3, 8'd0);
    drain("t4", 300);
    chk("t4_id0",  32'(log_id[0]), 32'd0);
    chk("t4_id1",  32'(log_id[1]), 32'd0);
    chk("t4_id2",  32'(log_id[2]), 32'd1);
    chk("t4_read", 32'(log_data[0]), 32'd42);
    chk("t4_arr3", 32'(arr[3]), 32'd0);

    // Lock limit forces release after LOCK_MAX completions.
    clear_logs();
    for (int k = 0; k < 6; k++) push(0, 1'b1, 1'b1, 8'(40 + k), 8'(k));
    push(1, 1'b1, 1'b0, 8'd50, 8'd77);
    drain("t5", 500);
    first1 = -1;
    for (int k = log_id.size() - 1; k >= 0; k--) if (log_id[k] == 1) first1 = k;
    chk("t5_count",   32'(log_id.size()), 32'd7);
    chk("t5_release", 32'(first1), 32'd4);

    // Reset while a transaction waits on the array.
    clear_logs();
    mem_hold = 1'b1;
    push(1, 1'b0, 1'b0, 8'd5, 8'd0);
    for (int k = 0; k < 4; k++) cycle();
    chk("t6_no_early_ready", 32'(log_id.size()), 32'd0);
    push(0, 1'b1, 1'b0, 8'd6, 8'd7);
    do_reset();
    chk("t6_model_idle", 32'(m_owner), 32'hffff_ffff);
    cycle();
    chk("t6_mem_valid_post_rst", 32'(bus.mem_valid), 32'd0);
    chk("t6_ready_post_rst", 32'(dut_rdy_cnt[0] + dut_rdy_cnt[1]), 32'd0);
    mem_hold = 1'b0;
    drain("t6", 300);
    chk("t6_first",  32'(log_id[0]), 32'd0);
    chk("t6_second", 32'(log_id[1]), 32'd1);

    // Randomized traffic with aborts, locks and occasional resets.
    clear_logs();
    abort_pct = 5;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) ready_pct = $urandom_range(20, 100);
      for (int i = 0; i < NREQ; i++) begin
        if (q_tail[i] - q_head[i] < 3 && $urandom_range(0, 99) < 30)
          push(i, 1'($urandom), ($urandom_range(0, 99) < 40), 8'($urandom_range(0, 7)), 8'($urandom));
      end
      rst_next = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst_next  = 1'b0;
    abort_pct = 0;
    ready_pct = 60;
    drain("rand", 2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
